// File: rtl/pcs_tx_ordered_set_pkg.sv
// -----------------------------------------------------------------------------
// pcs_tx_ordered_set_pkg
//   Shared definitions for the PCS transmit ordered-set generator: xmit
//   encodings, ordered-set type codes, special code-group octets and the
//   transmit FSM state encoding (also used by the PCS receive stage).
// -----------------------------------------------------------------------------
package pcs_tx_ordered_set_pkg;

    // One-hot xmit control from the auto-negotiation block.
    typedef enum logic [2:0] {
        XMIT_IDLE   = 3'b001,
        XMIT_CONFIG = 3'b010,
        XMIT_DATA   = 3'b100
    } xmit_t;

    // Ordered-set type reported alongside each code-group.
    typedef enum logic [2:0] {
        OS_I = 3'd0,
        OS_S = 3'd1,
        OS_D = 3'd2,
        OS_T = 3'd3,
        OS_R = 3'd4,
        OS_V = 3'd5
    } os_t;

    // Special code-group octets (all sent with K flag set).
    localparam logic [7:0] K_28_5 = 8'hBC;  // comma, even half of /I/
    localparam logic [7:0] K_27_7 = 8'hFB;  // /S/ start of packet
    localparam logic [7:0] K_29_7 = 8'hFD;  // /T/ end of packet
    localparam logic [7:0] K_23_7 = 8'hF7;  // /R/ carrier extend
    localparam logic [7:0] K_30_7 = 8'hFE;  // /V/ error propagation

    // Transmit FSM states.
    typedef enum logic [2:0] {
        ST_TX_TEST_XMIT = 3'd0,
        ST_XMIT_DATA    = 3'd1,
        ST_TX_PACKET    = 3'd2,
        ST_EPD2         = 3'd3,
        ST_EPD3         = 3'd4
    } tx_state_t;

endpackage

// File: rtl/pcs_tx_ordered_set.sv
// -----------------------------------------------------------------------------
// pcs_tx_ordered_set
//   PCS transmit ordered-set generator. Converts GMII TXD/TX_EN/TX_ER into one
//   code-group per GTX_CLK (ordered-set type, octet, K flag) for the 8b/10b
//   encoder, keeping /I/ pairs aligned to even positions and padding the
//   end-of-packet with one or two /R/ so idle always restarts on even.
//
// Ports
//   GTX_CLK        in   transmit clock, rising edge
//   mr_main_reset  in   asynchronous active-low reset
//   TXD[7:0]       in   GMII transmit data
//   TX_EN          in   GMII transmit enable
//   TX_ER          in   GMII transmit error
//   xmit[2:0]      in   one-hot IDLE / CONFIGURATION / DATA
//   tx_o_set[2:0]  out  ordered-set type of the current code-group
//   tx_octet[7:0]  out  code-group octet
//   tx_is_k        out  1 = special (K) code-group
//   tx_even        out  1 = current code-group is in an even position
//   transmitting   out  high from /S/ through the last /R/, to carrier sense
// -----------------------------------------------------------------------------
module pcs_tx_ordered_set
    import pcs_tx_ordered_set_pkg::*;
#(
    parameter logic [7:0] IDLE_D = 8'h50   // odd half of /I/ (D16.2 = /I2/)
) (
    input  logic       GTX_CLK,
    input  logic       mr_main_reset,
    input  logic [7:0] TXD,
    input  logic       TX_EN,
    input  logic       TX_ER,
    input  logic [2:0] xmit,
    output logic [2:0] tx_o_set,
    output logic [7:0] tx_octet,
    output logic       tx_is_k,
    output logic       tx_even,
    output logic       transmitting
);

    tx_state_t  state_q, state_d;
    os_t        os_d;
    logic [7:0] octet_d;
    logic       k_d;
    logic       trans_d;

    logic       next_even;   // parity of the code-group produced at this edge
    logic       xmit_data;
    logic       frame_start;
    tx_state_t  epd_exit;    // where the end-of-packet sequence returns to

    assign next_even   = ~tx_even;
    assign xmit_data   = (xmit == XMIT_DATA);
    assign frame_start = TX_EN & ~TX_ER;
    assign epd_exit    = xmit_data ? ST_XMIT_DATA : ST_TX_TEST_XMIT;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can
        // leave one unassigned and infer a latch.
        state_d = state_q;
        os_d    = OS_I;
        octet_d = next_even ? K_28_5 : IDLE_D;   // /I/ half matching the position
        k_d     = next_even;
        trans_d = 1'b0;

        case (state_q)
            ST_TX_TEST_XMIT: begin
                // CONFIGURATION is unsupported: anything but DATA keeps idling.
                if (next_even && xmit_data) begin
                    state_d = ST_XMIT_DATA;
                end
            end

            ST_XMIT_DATA: begin
                if (xmit_data && frame_start && next_even) begin
                    // /S/ overwrites this cycle's preamble octet. A mid-pair start
                    // falls through to the default IDLE_D and /S/ lands one cycle
                    // later, costing one preamble octet.
                    os_d    = OS_S;
                    octet_d = K_27_7;
                    k_d     = 1'b1;
                    trans_d = 1'b1;
                    state_d = ST_TX_PACKET;
                end else if (next_even && !xmit_data) begin
                    state_d = ST_TX_TEST_XMIT;
                end
            end

            ST_TX_PACKET: begin
                trans_d = 1'b1;
                if (!TX_EN) begin
                    os_d    = OS_T;
                    octet_d = K_29_7;
                    k_d     = 1'b1;
                    state_d = ST_EPD2;
                end else if (TX_ER) begin
                    os_d    = OS_V;
                    octet_d = K_30_7;
                    k_d     = 1'b1;
                end else begin
                    os_d    = OS_D;
                    octet_d = TXD;
                    k_d     = 1'b0;
                end
            end

            ST_EPD2: begin
                os_d    = OS_R;
                octet_d = K_23_7;
                k_d     = 1'b1;
                trans_d = 1'b1;
                // An /R/ on an even position needs a second one to realign idle.
                state_d = next_even ? ST_EPD3 : epd_exit;
            end

            ST_EPD3: begin
                os_d    = OS_R;
                octet_d = K_23_7;
                k_d     = 1'b1;
                trans_d = 1'b1;
                state_d = epd_exit;
            end

            default: state_d = ST_TX_TEST_XMIT;
        endcase
    end

    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            // NOTE: the output registers are reset along with the FSM because the
            // encoder consumes them directly; a stale code-group must not leak out.
            state_q      <= ST_TX_TEST_XMIT;
            tx_o_set     <= OS_I;
            tx_octet     <= 8'h00;
            tx_is_k      <= 1'b0;
            tx_even      <= 1'b0;
            transmitting <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q      <= state_d;
            tx_o_set     <= os_d;
            tx_octet     <= octet_d;
            tx_is_k      <= k_d;
            tx_even      <= next_even;
            transmitting <= trans_d;
        end
    end

endmodule

// File: tb/tb_pcs_tx_ordered_set.sv
// -----------------------------------------------------------------------------
// tb_pcs_tx_ordered_set
//   Self-checking bench for pcs_tx_ordered_set. A frame-level reference model
//   (position counter, idle/packet/pad bookkeeping) predicts every code-group;
//   directed scenarios additionally check the literal octet sequences.
// -----------------------------------------------------------------------------
module tb_pcs_tx_ordered_set;

    localparam logic [2:0] X_IDLE = 3'b001;
    localparam logic [2:0] X_CONF = 3'b010;
    localparam logic [2:0] X_DATA = 3'b100;

    localparam logic [2:0] E_OS_I = 3'd0;
    localparam logic [2:0] E_OS_S = 3'd1;
    localparam logic [2:0] E_OS_D = 3'd2;
    localparam logic [2:0] E_OS_T = 3'd3;
    localparam logic [2:0] E_OS_R = 3'd4;
    localparam logic [2:0] E_OS_V = 3'd5;

    localparam logic [7:0] IDLE_ODD = 8'h50;

    typedef struct packed {
        logic       en;
        logic       er;
        logic [7:0] d;
        logic [2:0] x;
    } stim_t;

    logic       GTX_CLK;
    logic       mr_main_reset;
    logic [7:0] TXD;
    logic       TX_EN;
    logic       TX_ER;
    logic [2:0] xmit;
    logic [2:0] tx_o_set;
    logic [7:0] tx_octet;
    logic       tx_is_k;
    logic       tx_even;
    logic       transmitting;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int         m_pos;        // code-group index since reset; even index = even position
    bit         m_data_mode;  // idle has committed to DATA at a pair boundary
    bit         m_in_pkt;
    int         m_r_left;     // /R/ code-groups still owed after /T/
    logic [2:0] e_os;
    logic [7:0] e_oct;
    logic       e_k;
    logic       e_even;
    logic       e_trans;

    // Captures from the last stimulus run.
    logic [7:0] got_oct[$];
    bit         got_even[$];
    bit         got_k[$];
    bit         got_tr[$];

    pcs_tx_ordered_set #(.IDLE_D(IDLE_ODD)) dut (
        .GTX_CLK      (GTX_CLK),
        .mr_main_reset(mr_main_reset),
        .TXD          (TXD),
        .TX_EN        (TX_EN),
        .TX_ER        (TX_ER),
        .xmit         (xmit),
        .tx_o_set     (tx_o_set),
        .tx_octet     (tx_octet),
        .tx_is_k      (tx_is_k),
        .tx_even      (tx_even),
        .transmitting (transmitting)
    );

    initial GTX_CLK = 1'b0;
    always #5 GTX_CLK = ~GTX_CLK;

    function automatic logic [13:0] obs();
        return {tx_o_set, tx_octet, tx_is_k, tx_even, transmitting};
    endfunction

    function automatic logic [13:0] expv();
        return {e_os, e_oct, e_k, e_even, e_trans};
    endfunction

    function automatic stim_t mk(logic en, logic er, logic [7:0] d, logic [2:0] x);
        stim_t s;
        s.en = en; s.er = er; s.d = d; s.x = x;
        return s;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_data_mode = 0; m_in_pkt = 0; m_r_left = 0;
    endtask

    // Predict the code-group produced by the current edge from the inputs.
    task automatic model_edge();
        bit even;
        even    = (m_pos % 2 == 0);
        e_even  = even;
        e_trans = 1'b1;
        e_k     = 1'b1;
        if (m_r_left > 0) begin
            e_os = E_OS_R; e_oct = 8'hF7;
            m_r_left--;
            if (m_r_left == 0) m_data_mode = (xmit == X_DATA);
        end else if (m_in_pkt) begin
            if (!TX_EN) begin
                e_os = E_OS_T; e_oct = 8'hFD;
                m_in_pkt = 0;
                // pad with /R/ until the following code-group is even
                m_r_left = ((m_pos + 1) % 2 == 1) ? 1 : 2;
            end else if (TX_ER) begin
                e_os = E_OS_V; e_oct = 8'hFE;
            end else begin
                e_os = E_OS_D; e_oct = TXD; e_k = 1'b0;
            end
        end else if (m_data_mode && xmit == X_DATA && TX_EN && !TX_ER && even) begin
            e_os = E_OS_S; e_oct = 8'hFB;
            m_in_pkt = 1;
        end else begin
            e_trans = 1'b0;
            e_os    = E_OS_I;
            e_oct   = even ? 8'hBC : IDLE_ODD;
            e_k     = even;
            if (even) m_data_mode = (xmit == X_DATA);
        end
        m_pos++;
    endtask

    task automatic step();
        @(posedge GTX_CLK);
        model_edge();
        #1;
    endtask

    task automatic apply(input stim_t s);
        TX_EN = s.en; TX_ER = s.er; TXD = s.d; xmit = s.x;
    endtask

    // Idle in DATA mode until the next code-group will be even (bounded).
    task automatic idle_to_boundary(input bit next_even_wanted);
        int n;
        apply(mk(1'b0, 1'b0, 8'h00, X_DATA));
        step(); step();
        n = 0;
        while ((~tx_even) !== next_even_wanted && n < 4) begin
            step();
            n++;
        end
        checks++;
        if ((~tx_even) !== next_even_wanted) begin
            errors++;
            $display("FAIL align: tx_even=%b, next parity %b required", tx_even, next_even_wanted);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (obs() !== 14'h0) begin
            errors++;
            $display("FAIL reset_async: got %h want %h", obs(), 14'h0);
        end
        @(posedge GTX_CLK); #1;
        checks++;
        if (obs() !== 14'h0) begin
            errors++;
            $display("FAIL reset_held: got %h want %h", obs(), 14'h0);
        end
        #2;
        mr_main_reset = 1'b1;
        model_reset();
    endtask

    task automatic test_idle();
        apply(mk(1'b0, 1'b0, 8'h00, X_DATA));
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL idle_model cyc %0d: got %h want %h", i, obs(), expv());
            end
            checks++;
            if ({tx_octet, tx_is_k, tx_even} !== {((i % 2 == 0) ? 8'hBC : 8'h50), (i % 2 == 0), (i % 2 == 0)}) begin
                errors++;
                $display("FAIL idle_pattern cyc %0d: got %h/%b/%b", i, tx_octet, tx_is_k, tx_even);
            end
        end
    endtask

    // Drive a stimulus list, comparing every cycle with the model and capturing.
    task automatic run_list(input string name, input stim_t s[$]);
        got_oct.delete(); got_even.delete(); got_k.delete(); got_tr.delete();
        foreach (s[i]) begin
            apply(s[i]);
            step();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL %s cyc %0d: got %h want %h", name, i, obs(), expv());
            end
            got_oct.push_back(tx_octet);
            got_even.push_back(tx_even);
            got_k.push_back(tx_is_k);
            got_tr.push_back(transmitting);
        end
    endtask

    task automatic add_frame(inout stim_t s[$], input int ndata, input logic [2:0] x);
        for (int i = 0; i < 7; i++) s.push_back(mk(1'b1, 1'b0, 8'h55, x));
        s.push_back(mk(1'b1, 1'b0, 8'hD5, x));
        for (int i = 0; i < ndata; i++) s.push_back(mk(1'b1, 1'b0, 8'($urandom), x));
    endtask

    task automatic test_boundary_frame();
        stim_t s[$];
        logic [7:0] want[$];
        bit ok;
        idle_to_boundary(1'b1);
        add_frame(s, 8, X_DATA);
        for (int i = 0; i < 3; i++) s.push_back(mk(1'b0, 1'b0, 8'h00, X_DATA));
        want.push_back(8'hFB);
        for (int i = 1; i < 16; i++) want.push_back(s[i].d);
        want.push_back(8'hFD); want.push_back(8'hF7); want.push_back(8'hBC);
        run_list("boundary_frame", s);
        ok = 1;
        foreach (want[i]) if (got_oct[i] !== want[i]) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL boundary_seq: first=%h fd=%h r=%h last=%h", got_oct[0], got_oct[16], got_oct[17], got_oct[18]);
        end
        ok = 1;
        for (int i = 0; i < 18; i++) if (!got_tr[i]) ok = 0;
        checks++;
        if (!ok || got_tr[18]) begin
            errors++;
            $display("FAIL boundary_transmitting: last=%b window_ok=%b", got_tr[18], ok);
        end
        checks++;
        if ({got_even[17], got_even[18]} !== 2'b01) begin
            errors++;
            $display("FAIL boundary_r_parity: got %b%b want 01", got_even[17], got_even[18]);
        end
    endtask

    task automatic test_midpair_frame();
        stim_t s[$];
        idle_to_boundary(1'b0);
        add_frame(s, 8, X_DATA);
        for (int i = 0; i < 4; i++) s.push_back(mk(1'b0, 1'b0, 8'h00, X_DATA));
        run_list("midpair_frame", s);
        checks++;
        if ({got_oct[0], got_oct[1], got_tr[0]} !== {IDLE_ODD, 8'hFB, 1'b0}) begin
            errors++;
            $display("FAIL midpair_start: got %h %h tr=%b want 50 FB tr=0", got_oct[0], got_oct[1], got_tr[0]);
        end
        checks++;
        if ({got_oct[16], got_oct[17], got_oct[18], got_oct[19]} !== {8'hFD, 8'hF7, 8'hF7, 8'hBC}) begin
            errors++;
            $display("FAIL midpair_tail: got %h %h %h %h want FD F7 F7 BC", got_oct[16], got_oct[17], got_oct[18], got_oct[19]);
        end
    endtask

    task automatic test_odd_frame();
        stim_t s[$];
        idle_to_boundary(1'b1);
        add_frame(s, 7, X_DATA);
        for (int i = 0; i < 4; i++) s.push_back(mk(1'b0, 1'b0, 8'h00, X_DATA));
        run_list("odd_frame", s);
        checks++;
        if ({got_oct[15], got_oct[16], got_oct[17], got_oct[18]} !== {8'hFD, 8'hF7, 8'hF7, 8'hBC}) begin
            errors++;
            $display("FAIL odd_tail: got %h %h %h %h want FD F7 F7 BC", got_oct[15], got_oct[16], got_oct[17], got_oct[18]);
        end
        checks++;
        if ({got_even[18], got_tr[17], got_tr[18]} !== 3'b110) begin
            errors++;
            $display("FAIL odd_bc_even: even=%b tr=%b%b want 1 10", got_even[18], got_tr[17], got_tr[18]);
        end
    endtask

    task automatic test_error_xmit();
        stim_t s[$];
        bit ok;
        idle_to_boundary(1'b1);
        add_frame(s, 10, X_DATA);
        s[12].er = 1'b1;
        s[13].er = 1'b1;
        for (int i = 15; i < 18; i++) s[i].x = X_IDLE;
        for (int i = 0; i < 3; i++) s.push_back(mk(1'b0, 1'b0, 8'h00, X_IDLE));
        for (int i = 0; i < 6; i++) s.push_back(mk(1'b1, 1'b0, 8'($urandom), X_IDLE));
        run_list("error_xmit", s);
        checks++;
        if ({got_oct[12], got_k[12], got_oct[13], got_k[13]} !== {8'hFE, 1'b1, 8'hFE, 1'b1}) begin
            errors++;
            $display("FAIL error_v: got %h/%b %h/%b want FE/1 FE/1", got_oct[12], got_k[12], got_oct[13], got_k[13]);
        end
        checks++;
        if ({got_oct[14], got_k[14], got_oct[18], got_oct[19]} !== {s[14].d, 1'b0, 8'hFD, 8'hF7}) begin
            errors++;
            $display("FAIL error_resume: got %h/%b %h %h", got_oct[14], got_k[14], got_oct[18], got_oct[19]);
        end
        ok = 1;
        for (int i = 20; i < 27; i++)
            if (got_tr[i] || got_oct[i] !== ((i % 2 == 0) ? 8'hBC : IDLE_ODD)) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL xmit_idle_ignores_en: idle after frame not clean, last oct %h tr %b", got_oct[26], got_tr[26]);
        end
    endtask

    task automatic test_async_reset();
        stim_t s[$];
        bit ok;
        idle_to_boundary(1'b1);
        add_frame(s, 2, X_DATA);
        run_list("reset_prefix", s);
        mr_main_reset = 1'b0;
        apply(mk(1'b0, 1'b0, 8'h00, X_DATA));
        #1;
        checks++;
        if (obs() !== 14'h0) begin
            errors++;
            $display("FAIL midframe_reset: got %h want %h", obs(), 14'h0);
        end
        @(posedge GTX_CLK); #2;
        mr_main_reset = 1'b1;
        model_reset();
        s.delete();
        for (int i = 0; i < 6; i++) s.push_back(mk(1'b0, 1'b0, 8'h00, X_DATA));
        run_list("after_reset", s);
        ok = 1;
        foreach (got_oct[i])
            if (got_tr[i] || got_oct[i] !== ((i % 2 == 0) ? 8'hBC : IDLE_ODD)) ok = 0;
        checks++;
        if (!ok || got_even[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_resume: first %h even %b clean %b want BC 1 1", got_oct[0], got_even[0], ok);
        end
    endtask

    task automatic test_random();
        stim_t s[$];
        int en_left, gap_left;
        logic [2:0] x;
        en_left = 0; gap_left = 0; x = X_DATA;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                case ($urandom_range(0, 3))
                    0:       x = X_IDLE;
                    1:       x = X_CONF;
                    default: x = X_DATA;
                endcase
            end
            if (en_left == 0 && gap_left == 0) begin
                en_left  = $urandom_range(1, 20);
                gap_left = $urandom_range(0, 6);
            end
            if (en_left > 0) begin
                s.push_back(mk(1'b1, ($urandom_range(0, 11) == 0), 8'($urandom), x));
                en_left--;
            end else begin
                s.push_back(mk(1'b0, ($urandom_range(0, 7) == 0), 8'($urandom), x));
                gap_left--;
            end
        end
        run_list("random", s);
    endtask

    initial begin
        mr_main_reset = 1'b1;
        TXD   = 8'h00;
        TX_EN = 1'b0;
        TX_ER = 1'b0;
        xmit  = X_DATA;
        model_reset();
        e_os = E_OS_I; e_oct = 8'h00; e_k = 1'b0; e_even = 1'b0; e_trans = 1'b0;
        #1 mr_main_reset = 1'b0;

        test_reset();
        test_idle();
        test_boundary_frame();
        test_midpair_frame();
        test_odd_frame();
        test_error_xmit();
        test_async_reset();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
